radix_counter_display: RTL and testbench

// - Parametrised successor of the fixed 12-bit counter/display top: one clock domain, a tick enable instead of a divided clock.
// - Holds a P_WIDTH-bit up/down/shift counter and converts it sequentially to P_DIGITS seven-segment digits.
// - Display radix is selectable: decimal (iterative double-dabble), octal or hex.
// - Drives the board LEDs and displays directly.

---
 rtl/display_pkg.sv | 51 +++++
 rtl/radix_counter_display_tick_gen.sv | 20 ++
 rtl/radix_counter_display.sv | 151 +++++++++++++++
 tb/tb_radix_counter_display.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and seven-segment helpers for the radix counter display.
package display_pkg;

    typedef enum logic [1:0] {
        RADIX_DEC = 2'd0,
        RADIX_OCT = 2'd1,
        RADIX_HEX = 2'd2
    } radix_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } conv_state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low segments, bit0 = a .. bit6 = g.
    function automatic logic [6:0] seg7_encode(input logic [3:0] v);
        case (v)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Radix code 11 is treated as decimal.
    function automatic radix_e radix_decode(input logic [1:0] r);
        case (r)
            2'b01:   return RADIX_OCT;
            2'b10:   return RADIX_HEX;
            default: return RADIX_DEC;
        endcase
    endfunction

endpackage

// File: rtl/radix_counter_display_tick_gen.sv
// Free-running divider: one-cycle o_tick every P_DIV clocks, independent of pause.
module tick_gen #(
    parameter int P_DIV = 10000
) (
    input  logic i_clk,
    input  logic reset,
    output logic o_tick
);
    localparam int CW = $clog2(P_DIV);

    logic [CW-1:0] cnt;

    assign o_tick = (cnt == CW'(P_DIV - 1));

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset)      cnt <= '0;
        else if (o_tick) cnt <= '0;
        else             cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/radix_counter_display.sv
// Up/down/shift counter with a sequential binary-to-digit converter driving
// P_DIGITS active-low seven-segment digits in decimal, octal or hex.
module radix_counter_display
    import display_pkg::*;
#(
    parameter int          P_WIDTH  = 12,
    parameter int          P_DIGITS = 4,
    parameter logic [31:0] P_INIT   = 32'hB78,
    parameter int          P_DIV    = 10000,
    parameter int          P_SHL    = 2,
    parameter int          P_SHR    = 1
) (
    input  logic                    i_clk,
    input  logic                    reset,
    input  logic                    input_pause,
    input  logic                    dcrm,
    input  logic                    shift_left,
    input  logic                    shift_right,
    input  logic                    set,
    input  logic [1:0]              radix,
    output logic                    o_tick,
    output logic [P_WIDTH-1:0]      data,
    output logic [7*P_DIGITS-1:0]   seg,
    output logic                    seg_valid,
    output logic                    overflow,
    output logic [P_WIDTH-1:0]      LEDS
);
    localparam logic [P_WIDTH-1:0] INIT_V = P_INIT[P_WIDTH-1:0];
    // BCD digits needed to hold 2^P_WIDTH-1 (floor(W*log10 2)+1).
    localparam int BCD_N = (P_WIDTH * 301) / 1000 + 1;
    localparam int BW    = 4 * BCD_N;
    localparam int IW    = $clog2(P_WIDTH + 1);

    tick_gen #(.P_DIV(P_DIV)) u_tick (
        .i_clk  (i_clk),
        .reset  (reset),
        .o_tick (o_tick)
    );

    // ---------------- counter ----------------
    logic [P_WIDTH-1:0] data_nxt;

    always_comb begin
        data_nxt = data;
        if (o_tick && !input_pause) begin
            if (set)              data_nxt = INIT_V;
            else if (shift_left)  data_nxt = data << P_SHL;
            else if (shift_right) data_nxt = data >> P_SHR;
            else if (dcrm)        data_nxt = data - 1'b1;
            else                  data_nxt = data + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) data <= INIT_V;
        else        data <= data_nxt;
    end

    assign LEDS = data;

    // ---------------- conversion ----------------
    conv_state_e                state;
    logic                       pending;
    logic [1:0]                 radix_q;
    logic [P_WIDTH-1:0]         snap;
    radix_e                     snap_radix;
    logic [BW-1:0]              bcd;
    logic [IW-1:0]              iter;

    logic                       chg;
    logic [BW-1:0]              bcd_adj;
    logic [P_WIDTH+4*P_DIGITS-1:0] pad_bin;
    logic [BW+4*P_DIGITS-1:0]   pad_bcd;
    logic [3:0]                 nib;
    logic                       ovf_c;
    logic [7*P_DIGITS-1:0]      seg_c;

    // A radix edge is seen combinationally so an idle converter starts at once.
    assign chg = (data_nxt != data) || (radix != radix_q);

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < BCD_N; k++)
            if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end

    always_comb begin
        pad_bin = '0;
        pad_bin[P_WIDTH-1:0] = snap;
        pad_bcd = '0;
        pad_bcd[BW-1:0] = bcd;
        nib   = '0;
        seg_c = '0;
        case (snap_radix)
            RADIX_OCT: ovf_c = |(pad_bin >> (3 * P_DIGITS));
            RADIX_HEX: ovf_c = |(pad_bin >> (4 * P_DIGITS));
            default:   ovf_c = |(pad_bcd >> (4 * P_DIGITS));
        endcase
        for (int k = 0; k < P_DIGITS; k++) begin
            case (snap_radix)
                RADIX_OCT: nib = {1'b0, pad_bin[3*k +: 3]};
                RADIX_HEX: nib = pad_bin[4*k +: 4];
                default:   nib = pad_bcd[4*k +: 4];
            endcase
            seg_c[7*k +: 7] = ovf_c ? SEG_DASH : seg7_encode(nib);
        end
    end

    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pending    <= 1'b1;
            radix_q    <= 2'b00;
            snap       <= '0;
            snap_radix <= RADIX_DEC;
            bcd        <= '0;
            iter       <= '0;
            seg        <= {P_DIGITS{SEG_BLANK}};
            seg_valid  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            seg_valid <= 1'b0;
            radix_q   <= radix;

            if (state == ST_IDLE && (pending || chg)) pending <= 1'b0;
            else if (chg)                             pending <= 1'b1;

            case (state)
                ST_IDLE: if (pending || chg) state <= ST_LOAD;
                ST_LOAD: begin
                    snap       <= data;
                    snap_radix <= radix_decode(radix);
                    bcd        <= '0;
                    iter       <= IW'(P_WIDTH);
                    state      <= (radix_decode(radix) == RADIX_DEC) ? ST_SHIFT : ST_DONE;
                end
                ST_SHIFT: begin
                    {bcd, snap} <= {bcd_adj, snap} << 1;
                    iter        <= iter - 1'b1;
                    if (iter == IW'(1)) state <= ST_DONE;
                end
                default: begin
                    seg       <= seg_c;
                    overflow  <= ovf_c;
                    seg_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_radix_counter_display.sv
// Directed bench: main instance plus two P_INIT=0 instances for wrap/overflow.
module tb_radix_counter_display;
    logic gclk = 1'b0;
    logic rst_n;
    always #5 gclk = ~gclk;

    logic        pause, dcrm, sl, sr, st;
    logic [1:0]  radix;
    logic        tick, sv, ovf;
    logic [11:0] data, leds;
    logic [27:0] seg;

    logic        z_pause, z_dcrm;
    logic        zt, zsv, zovf, z3t, z3sv, z3ovf;
    logic [11:0] zdata, zleds, z3data, z3leds;
    logic [27:0] zseg;
    logic [20:0] z3seg;

    radix_counter_display #(.P_WIDTH(12), .P_DIGITS(4), .P_DIV(4)) u_dut (
        .i_clk(gclk), .reset(rst_n), .input_pause(pause), .dcrm(dcrm),
        .shift_left(sl), .shift_right(sr), .set(st), .radix(radix),
        .o_tick(tick), .data(data), .seg(seg), .seg_valid(sv),
        .overflow(ovf), .LEDS(leds));

    radix_counter_display #(.P_WIDTH(12), .P_DIGITS(4), .P_INIT(32'h0), .P_DIV(4)) u_dz (
        .i_clk(gclk), .reset(rst_n), .input_pause(z_pause), .dcrm(z_dcrm),
        .shift_left(1'b0), .shift_right(1'b0), .set(1'b0), .radix(2'b00),
        .o_tick(zt), .data(zdata), .seg(zseg), .seg_valid(zsv),
        .overflow(zovf), .LEDS(zleds));

    radix_counter_display #(.P_WIDTH(12), .P_DIGITS(3), .P_INIT(32'h0), .P_DIV(4)) u_dz3 (
        .i_clk(gclk), .reset(rst_n), .input_pause(z_pause), .dcrm(z_dcrm),
        .shift_left(1'b0), .shift_right(1'b0), .set(1'b0), .radix(2'b00),
        .o_tick(z3t), .data(z3data), .seg(z3seg), .seg_valid(z3sv),
        .overflow(z3ovf), .LEDS(z3leds));

    // Active-low glyphs 0..F, digit 0 in the low 7 bits.
    localparam logic [16*7-1:0] SEGT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] sg(input int d);
        return SEGT[7*d +: 7];
    endfunction

    function automatic logic [27:0] d4(input int a, input int b, input int c, input int e);
        return {sg(a), sg(b), sg(c), sg(e)};
    endfunction

    task automatic wait_sv(input int which, input int bound, input string tag, output int lat);
        int i;
        i   = 0;
        lat = -1;
        while (lat < 0 && i < bound) begin
            @(negedge gclk);
            i++;
            if ((which == 0 && sv) || (which == 1 && zsv)) lat = i;
        end
        if (lat < 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic tick_once(input logic l, input logic r, input logic s, input logic d);
        int i;
        i = 0;
        while (!tick && i < 20) begin
            @(negedge gclk);
            i++;
        end
        if (!tick) chk("tick_timeout", 64'd0, 64'd1);
        pause = 1'b0; sl = l; sr = r; st = s; dcrm = d;
        @(negedge gclk);
        pause = 1'b1; sl = 1'b0; sr = 1'b0; st = 1'b0; dcrm = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nt, nsv;
        rst_n = 1'b0; pause = 1'b1; dcrm = 1'b0; sl = 1'b0; sr = 1'b0; st = 1'b0;
        radix = 2'b00; z_pause = 1'b1; z_dcrm = 1'b0;
        #12;
        chk("rst_data", data, 12'hB78);
        chk("rst_leds", leds, 12'hB78);
        chk("rst_seg", seg, 28'hFFFFFFF);
        chk("rst_sv", sv, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_tick", tick, 1'b0);

        @(negedge gclk);
        rst_n = 1'b1;
        wait_sv(0, 40, "init", lat);
        chk("init_lat", lat, 15);
        chk("init_dec", seg, d4(2, 9, 3, 6));
        chk("init_ovf", ovf, 1'b0);
        @(negedge gclk);
        chk("sv_pulse", sv, 1'b0);

        radix = 2'b10;
        wait_sv(0, 20, "hex", lat);
        chk("hex_lat", lat, 3);
        chk("hex_seg", seg, d4(0, 11, 7, 8));
        radix = 2'b01;
        wait_sv(0, 20, "oct", lat);
        chk("oct_lat", lat, 3);
        chk("oct_seg", seg, d4(5, 5, 7, 0));
        radix = 2'b00;
        wait_sv(0, 40, "dec_back", lat);
        chk("dec_back", seg, d4(2, 9, 3, 6));

        tick_once(1'b1, 1'b0, 1'b0, 1'b0);
        chk("shl_data", data, 12'hDE0);
        chk("shl_leds", leds, 12'hDE0);
        wait_sv(0, 40, "shl", lat);
        chk("shl_seg", seg, d4(3, 5, 5, 2));
        tick_once(1'b0, 1'b1, 1'b0, 1'b0);
        chk("shr_data", data, 12'h6F0);
        wait_sv(0, 40, "shr", lat);
        chk("shr_seg", seg, d4(1, 7, 7, 6));
        tick_once(1'b1, 1'b0, 1'b1, 1'b0);
        chk("set_data", data, 12'hB78);
        wait_sv(0, 40, "set", lat);
        chk("set_seg", seg, d4(2, 9, 3, 6));

        tick_once(1'b0, 1'b0, 1'b0, 1'b1);
        chk("dec_data", data, 12'hB77);
        tick_once(1'b0, 1'b0, 1'b0, 1'b0);
        chk("inc_data", data, 12'hB78);
        wait_sv(0, 40, "incdec1", lat);
        chk("incdec1_seg", seg, d4(2, 9, 3, 5));
        wait_sv(0, 40, "incdec2", lat);
        chk("incdec2_seg", seg, d4(2, 9, 3, 6));

        nt = 0; nsv = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge gclk);
            nt  += int'(tick);
            nsv += int'(sv);
        end
        chk("pause_ticks", nt, 10);
        chk("pause_sv", nsv, 0);
        chk("pause_data", data, 12'hB78);
        chk("pause_seg", seg, d4(2, 9, 3, 6));

        // Second change lands mid-SHIFT of the first conversion.
        tick_once(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge gclk);
        tick_once(1'b0, 1'b1, 1'b0, 1'b0);
        chk("mid_data", data, 12'h5BC);
        wait_sv(0, 40, "mid1", lat);
        chk("mid1_seg", seg, d4(2, 9, 3, 7));
        wait_sv(0, 40, "mid2", lat);
        chk("mid2_seg", seg, d4(1, 4, 6, 8));

        tick_once(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge gclk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_seg", seg, 28'hFFFFFFF);
        chk("midrst_data", data, 12'hB78);
        chk("midrst_sv", sv, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        @(negedge gclk);
        rst_n = 1'b1;

        wait_sv(1, 40, "z_init", lat);
        chk("z_init_seg", zseg, d4(0, 0, 0, 0));
        chk("z3_init_seg", z3seg, {sg(0), sg(0), sg(0)});
        chk("z_init_ovf", zovf, 1'b0);
        begin
            int i;
            i = 0;
            while (!zt && i < 20) begin
                @(negedge gclk);
                i++;
            end
            if (!zt) chk("ztick_timeout", 64'd0, 64'd1);
        end
        z_pause = 1'b0; z_dcrm = 1'b1;
        @(negedge gclk);
        z_pause = 1'b1; z_dcrm = 1'b0;
        chk("wrap_data", zdata, 12'hFFF);
        chk("wrap_leds", zleds, 12'hFFF);
        chk("wrap3_data", z3data, 12'hFFF);
        chk("wrap3_leds", z3leds, 12'hFFF);
        wait_sv(1, 40, "wrap", lat);
        chk("wrap_seg", zseg, d4(4, 0, 9, 5));
        chk("wrap_ovf", zovf, 1'b0);
        chk("wrap3_sv", z3sv, 1'b1);
        chk("wrap3_ovf", z3ovf, 1'b1);
        chk("wrap3_seg", z3seg, {3{7'h3F}});
        chk("wrap3_tick", z3t, zt);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
